// File: rtl/frame_stream_sink_if.sv
// Pixel stream carrying RGB444 beats with sop/eop framing and valid/ready handshake.
interface frame_stream_sink_if #(
    parameter int unsigned DATA_W = 12
);
    logic [DATA_W-1:0] data_in;
    logic              sop_in;
    logic              eop_in;
    logic              valid_in;
    logic              ready_out;

    modport master (output data_in, sop_in, eop_in, valid_in, input ready_out);
    modport slave  (input data_in, sop_in, eop_in, valid_in, output ready_out);
endinterface

// File: rtl/frame_stream_sink.sv
// Stream sink: checks frame framing and turns accepted pixels into linear frame-buffer
// writes through a 2-entry skid buffer, so the upstream ready is a plain register.
module frame_stream_sink #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240,
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ADDR_W = 17
) (
    input  logic                clk,
    input  logic                reset,
    frame_stream_sink_if.slave  s,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    input  logic                wr_ready,
    output logic                frame_done,
    output logic                err_short,
    output logic                err_long,
    output logic [15:0]         frame_count
);
    localparam int unsigned       FRAME_PIXELS = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(FRAME_PIXELS - 1);
    localparam bit                SINGLE_PIXEL = (FRAME_PIXELS == 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DISCARD} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                accept;
    logic                push;
    logic [ADDR_W-1:0]   push_addr;
    logic                done_d, short_d, long_d;

    // Second skid slot; the head slot is the wr_* output register itself.
    logic                sk_valid;
    logic [ADDR_W-1:0]   sk_addr;
    logic [DATA_W-1:0]   sk_data;
    logic                pop;
    logic                head_v, skid_v, ready_d;
    logic [ADDR_W-1:0]   head_a, skid_a;
    logic [DATA_W-1:0]   head_dt, skid_dt;

    assign accept = s.valid_in & s.ready_out;
    assign pop    = wr_en & wr_ready;

    // Framing FSM: decides per accepted beat whether it is written and which pulse fires.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_addr = '0;
        done_d    = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        if (accept) begin
            if (s.sop_in) begin
                push      = 1'b1;
                push_addr = '0;
                short_d   = (state_q == ACTIVE);
                if (s.eop_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (SINGLE_PIXEL) done_d  = ~short_d;
                    else              short_d = 1'b1;
                end else if (SINGLE_PIXEL) begin
                    long_d  = 1'b1;
                    state_d = DISCARD;
                    cnt_d   = '0;
                end else begin
                    state_d = ACTIVE;
                    cnt_d   = ADDR_W'(1);
                end
            end else begin
                unique case (state_q)
                    ACTIVE: begin
                        push      = 1'b1;
                        push_addr = cnt_q;
                        if (s.eop_in) begin
                            if (cnt_q == LAST_IDX) done_d  = 1'b1;
                            else                   short_d = 1'b1;
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == LAST_IDX) begin
                            long_d  = 1'b1;
                            state_d = DISCARD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + ADDR_W'(1);
                        end
                    end
                    DISCARD: begin
                        if (s.eop_in) state_d = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Skid update: pop first, refill head from the skid slot, then place the new write.
    always_comb begin
        head_v  = wr_en & ~pop;
        head_a  = wr_addr;
        head_dt = wr_data;
        skid_v  = sk_valid;
        skid_a  = sk_addr;
        skid_dt = sk_data;
        if (!head_v && skid_v) begin
            head_v  = 1'b1;
            head_a  = skid_a;
            head_dt = skid_dt;
            skid_v  = 1'b0;
        end
        if (push) begin
            if (!head_v) begin
                head_v  = 1'b1;
                head_a  = push_addr;
                head_dt = s.data_in;
            end else begin
                skid_v  = 1'b1;
                skid_a  = push_addr;
                skid_dt = s.data_in;
            end
        end
        ready_d = ~(head_v & skid_v);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sk_valid    <= 1'b0;
            sk_addr     <= '0;
            sk_data     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            s.ready_out <= 1'b0;
            frame_done  <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            frame_count <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sk_valid    <= skid_v;
            sk_addr     <= skid_a;
            sk_data     <= skid_dt;
            wr_en       <= head_v;
            wr_addr     <= head_a;
            wr_data     <= head_dt;
            s.ready_out <= ready_d;
            frame_done  <= done_d;
            err_short   <= short_d;
            err_long    <= long_d;
            if (done_d) frame_count <= frame_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_frame_stream_sink.sv
// Self-checking bench: directed framing cases plus random traffic against a frame-level model.
module tb_frame_stream_sink;
    localparam int unsigned WIDTH  = 4;
    localparam int unsigned HEIGHT = 2;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned ADDR_W = 3;
    localparam int          FP     = WIDTH * HEIGHT;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr_en, wr_ready, frame_done, err_short, err_long;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [15:0]       frame_count;

    frame_stream_sink_if #(.DATA_W(DATA_W)) st ();

    frame_stream_sink #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .s(st),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .frame_done(frame_done), .err_short(err_short), .err_long(err_long),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int data; } wr_t;
    wr_t exp_q[$];
    int  n_checks = 0, n_fail = 0;
    bit  in_frame;
    int  pos;
    bit  exp_done, exp_short, exp_long, exp_ready;
    int  exp_fc;
    int  wr_mode, pat_idx;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Frame-level rules: where an accepted beat lands and which pulse it raises.
    task automatic model_beat(input bit sop, input bit eop, input int d);
        if (sop) begin
            if (in_frame) exp_short = 1;
            exp_q.push_back('{0, d % 4096});
            if (eop) begin
                exp_short = 1;
                in_frame  = 0;
            end else begin
                in_frame = 1;
                pos      = 1;
            end
        end else if (in_frame) begin
            exp_q.push_back('{pos, d % 4096});
            if (eop) begin
                if (pos == FP - 1) exp_done = 1; else exp_short = 1;
                in_frame = 0;
            end else if (pos == FP - 1) begin
                exp_long = 1;
                in_frame = 0;
            end else begin
                pos++;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("ready_out", 32'(st.ready_out), 32'(exp_ready));
        check_eq("wr_en", 32'(wr_en), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            check_eq("wr_addr", 32'(wr_addr), 32'(exp_q[0].addr));
            check_eq("wr_data", 32'(wr_data), 32'(exp_q[0].data));
        end
        check_eq("frame_done", 32'(frame_done), 32'(exp_done));
        check_eq("err_short", 32'(err_short), 32'(exp_short));
        check_eq("err_long", 32'(err_long), 32'(exp_long));
        check_eq("frame_count", 32'(frame_count), 32'(exp_fc));
    endtask

    // One clock: drive at negedge, check, advance the model across the next rising edge.
    task automatic cycle(input bit v, input bit sop, input bit eop, input int d, output bit acc);
        bit wrr;
        case (wr_mode)
            0: wrr = 1;
            1: begin wrr = (pat_idx % 4 == 0) || (pat_idx % 4 == 3); pat_idx++; end
            2: wrr = 1'($urandom_range(0, 1));
            default: wrr = 0;
        endcase
        st.valid_in = v; st.sop_in = sop; st.eop_in = eop;
        st.data_in  = DATA_W'(d);
        wr_ready    = wrr;
        #1;
        check_outputs();
        acc = v && exp_ready;
        if (wrr && exp_q.size() > 0) void'(exp_q.pop_front());
        exp_done = 0; exp_short = 0; exp_long = 0;
        if (acc) model_beat(sop, eop, d);
        if (exp_done) exp_fc = (exp_fc + 1) % 65536;
        exp_ready = exp_q.size() < 2;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_beat(input bit sop, input bit eop, input int d);
        bit acc = 0;
        for (int t = 0; t < 50 && !acc; t++) cycle(1, sop, eop, d, acc);
        if (!acc) check_eq("accept_timeout", 32'(acc), 32'(1));
    endtask

    task automatic send_frame(input int n, input int eop_at, input bit with_sop, input int base);
        for (int i = 0; i < n; i++) send_beat(with_sop && i == 0, i == eop_at, base + i);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, acc);
    endtask

    task automatic do_reset();
        st.valid_in = 0; st.sop_in = 0; st.eop_in = 0; st.data_in = '0; wr_ready = 0;
        #3 reset = 1'b0;
        #1;
        exp_q.delete();
        in_frame = 0; pos = 0;
        exp_done = 0; exp_short = 0; exp_long = 0; exp_fc = 0; exp_ready = 0;
        check_outputs();
        @(negedge clk);
        check_outputs();
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        wr_mode = 0; pat_idx = 0;
        st.valid_in = 0; st.sop_in = 0; st.eop_in = 0; st.data_in = '0; wr_ready = 0;
        @(negedge clk);
        do_reset();
        idle(2);
        check_eq("ready_after_reset", 32'(st.ready_out), 32'(1));

        send_frame(8, 7, 1, 1);
        idle(3);
        check_eq("fc_first_frame", 32'(frame_count), 32'(1));

        wr_mode = 1; pat_idx = 0;
        send_frame(8, 7, 1, 'h11);
        idle(8);
        wr_mode = 0; idle(3);

        send_beat(0, 0, 'h0AA);
        send_beat(0, 0, 'h0BB);
        send_frame(8, 7, 1, 'h21);
        idle(3);

        send_frame(4, 3, 1, 'h31);
        idle(2);
        send_frame(8, 7, 1, 'h41);
        idle(3);

        send_frame(10, 9, 1, 'h51);
        idle(3);
        check_eq("fc_after_long", 32'(frame_count), 32'(4));

        wr_mode = 3;
        for (int i = 0; i < 5; i++) cycle(1, i == 0, 0, 'h70 + i, acc);
        check_eq("stall_ready", 32'(st.ready_out), 32'(0));
        wr_mode = 0; idle(3);

        send_frame(3, -1, 1, 'h80);
        do_reset();
        send_frame(8, 7, 1, 'h91);
        idle(3);

        wr_mode = 2;
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) do_reset();
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 8) == 0, int'($urandom_range(0, 4095)), acc);
        end
        wr_mode = 0; idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
